// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - accumulator ALU driving the C bus; single-cycle ops plus iterative MUL/DIV
module alu_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] bbus_in,
  output logic [WIDTH-1:0] cbus_out,
  output logic             z_flag,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic             illegal
);

  localparam int CW = $clog2(ITER);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_CLAC = 4'b0001;
  localparam logic [3:0] OP_LDAC = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  ac_q, ac_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // MUL: wa=shifting multiplicand, wb=shifting multiplier, wr=partial product
  // DIV: wa=dividend shifting into quotient, wb=divisor, wr=partial remainder
  logic [WIDTH-1:0]  wa_q, wa_d, wb_q, wb_d, wr_q, wr_d;
  logic              done_q, done_d, ill_q, ill_d, div0_q, div0_d;

  logic [WIDTH-1:0]  mul_sum;
  logic [WIDTH:0]    div_shift;
  logic              div_ge;
  logic [WIDTH-1:0]  div_rem, div_quot;
  logic              last_iter;

  assign mul_sum   = wr_q + (wb_q[0] ? wa_q : '0);
  assign div_shift = {wr_q, wa_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, wb_q});
  assign div_rem   = WIDTH'(div_ge ? (div_shift - {1'b0, wb_q}) : div_shift);
  assign div_quot  = {wa_q[WIDTH-2:0], div_ge};
  assign last_iter = (cnt_q == CW'(ITER - 1));

  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    div0_d  = div0_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          div0_d = 1'b0;
          done_d = 1'b1;
          case (alu_op)
            OP_NOP:  ;
            OP_CLAC: ac_d = '0;
            OP_LDAC: ac_d = bbus_in;
            OP_ADD:  ac_d = ac_q + bbus_in;
            OP_SUB:  ac_d = ac_q - bbus_in;
            OP_INC:  ac_d = ac_q + WIDTH'(1);
            OP_SHL:  ac_d = ac_q << bbus_in[SW-1:0];
            OP_SHR:  ac_d = ac_q >> bbus_in[SW-1:0];
            OP_MUL, OP_DIV: begin
              done_d  = 1'b0;
              wa_d    = ac_q;
              wb_d    = bbus_in;
              wr_d    = '0;
              cnt_d   = '0;
              state_d = (alu_op == OP_MUL) ? S_MUL : S_DIV;
              div0_d  = (alu_op == OP_DIV) && (bbus_in == '0);
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      S_MUL: begin
        wr_d  = mul_sum;
        wa_d  = wa_q << 1;
        wb_d  = wb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          ac_d    = mul_sum;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        // A zero divisor never fails the compare, so the quotient fills with ones
        wr_d  = div_rem;
        wa_d  = div_quot;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          ac_d    = div_quot;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ac_q    <= '0;
      cnt_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      wr_q    <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      div0_q  <= div0_d;
    end
  end

  assign cbus_out = ac_q;
  assign z_flag   = (ac_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div0     = div0_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - bench for alu_unit: arithmetic reference model plus directed literal checks
module tb_alu_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] bbus_in = 32'd0;
  logic [31:0] cbus_out;
  logic        z_flag, busy, done, div0, illegal;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  alu_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock(clock), .reset(reset), .start(start), .alu_op(alu_op),
    .bbus_in(bbus_in), .cbus_out(cbus_out), .z_flag(z_flag), .busy(busy),
    .done(done), .div0(div0), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic at the start edge, result released after 32 busy cycles
  logic [31:0] m_ac = 0, m_res = 0;
  int          m_left = 0;
  bit          m_busy = 0, m_done = 0, m_ill = 0, m_div0 = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_ac = 0; m_busy = 0; m_left = 0; m_done = 0; m_ill = 0; m_div0 = 0;
    end else begin
      m_done = 0;
      m_ill  = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_ac = m_res; m_busy = 0; m_done = 1;
        end
      end else if (start) begin
        m_div0 = 0;
        m_done = 1;
        case (alu_op)
          4'd0: ;
          4'd1: m_ac = 0;
          4'd2: m_ac = bbus_in;
          4'd3: m_ac = m_ac + bbus_in;
          4'd4: m_ac = m_ac - bbus_in;
          4'd5: m_ac = m_ac + 1;
          4'd6: m_ac = m_ac << (bbus_in % 32);
          4'd7: m_ac = m_ac >> (bbus_in % 32);
          4'd8, 4'd9: begin
            m_done = 0; m_busy = 1; m_left = 32;
            if (alu_op == 4'd8) m_res = m_ac * bbus_in;
            else if (bbus_in == 0) begin m_res = 32'hFFFF_FFFF; m_div0 = 1; end
            else m_res = m_ac / bbus_in;
          end
          default: m_ill = 1;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model cbus_out", cbus_out, m_ac);
      check("model z_flag", {31'd0, z_flag}, {31'd0, m_ac == 0});
      check("model busy", {31'd0, busy}, {31'd0, m_busy});
      check("model done", {31'd0, done}, {31'd0, m_done});
      check("model div0", {31'd0, div0}, {31'd0, m_div0});
      check("model illegal", {31'd0, illegal}, {31'd0, m_ill});
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic do_op(input logic [3:0] op, input logic [31:0] b);
    start = 1'b1; alu_op = op; bbus_in = b;
    @(negedge clock);
    start = 1'b0; bbus_in = $urandom;
  endtask

  task automatic wait_done(output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    while (!done && n < 40) begin
      if (busy) busy_cycles++;
      bbus_in = $urandom;
      @(negedge clock);
      n++;
    end
    if (!done) check("wait_done timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bc;
    @(negedge clock); @(negedge clock);
    check("reset cbus_out", cbus_out, 32'd0);
    check("reset z_flag", {31'd0, z_flag}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div0", {31'd0, div0}, 32'd0);
    chk_en = 1'b1;
    reset = 1'b0;
    @(negedge clock);

    do_op(4'd2, 32'd5);   check("LDAC 5", cbus_out, 32'd5); check("LDAC done", {31'd0, done}, 32'd1);
    do_op(4'd3, 32'd7);   check("ADD 7", cbus_out, 32'd12);
    do_op(4'd4, 32'd12);  check("SUB 12", cbus_out, 32'd0); check("SUB z", {31'd0, z_flag}, 32'd1);
    do_op(4'd2, 32'hFFFF_FFFF);
    do_op(4'd5, 32'd0);   check("INC wrap", cbus_out, 32'd0); check("INC z", {31'd0, z_flag}, 32'd1);
    do_op(4'd2, 32'd3);
    do_op(4'd6, 32'd33);  check("SHL B=33", cbus_out, 32'd6);
    do_op(4'd2, 32'h8000_0010);
    do_op(4'd7, 32'd36);  check("SHR B=36", cbus_out, 32'h0800_0001);

    do_op(4'd2, 32'd1234);
    do_op(4'd8, 32'd5678);
    check("MUL holds AC", cbus_out, 32'd1234);
    wait_done(bc);
    check("MUL busy cycles", bc, 32'd32);
    check("MUL result", cbus_out, 32'd7006652);
    @(negedge clock);
    check("MUL single done", {31'd0, done}, 32'd0);

    do_op(4'd2, 32'h0001_0000);
    do_op(4'd8, 32'h0001_0000);
    wait_done(bc);        check("MUL wrap", cbus_out, 32'd0);

    do_op(4'd2, 32'd100);
    do_op(4'd9, 32'd7);
    wait_done(bc);        check("DIV 100/7", cbus_out, 32'd14); check("DIV div0", {31'd0, div0}, 32'd0);
    do_op(4'd9, 32'd0);
    wait_done(bc);        check("DIV by 0", cbus_out, 32'hFFFF_FFFF); check("DIV0 flag", {31'd0, div0}, 32'd1);
    do_op(4'd0, 32'd0);   check("NOP clears div0", {31'd0, div0}, 32'd0);

    // start while busy is dropped; start on the done cycle is accepted
    do_op(4'd2, 32'd3);
    do_op(4'd8, 32'd4);
    repeat (5) @(negedge clock);
    do_op(4'd3, 32'd100);
    wait_done(bc);        check("MUL ignores start", cbus_out, 32'd12);
    do_op(4'd3, 32'd1);   check("start on done", cbus_out, 32'd13);

    do_op(4'd2, 32'd9);
    do_op(4'd8, 32'd9);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort cbus_out", cbus_out, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    repeat (35) begin
      @(negedge clock);
      if (done) check("abort no done", {31'd0, done}, 32'd0);
    end

    do_op(4'd2, 32'd42);
    do_op(4'b1100, 32'd7);
    check("illegal pulse", {31'd0, illegal}, 32'd1);
    check("illegal done", {31'd0, done}, 32'd1);
    check("illegal AC", cbus_out, 32'd42);
    @(negedge clock);
    check("illegal one cycle", {31'd0, illegal}, 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
